// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file types and constants for the write-port arbiter slice.
package regfile_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // Register index that reads as zero; writes to it never reach the regfile.
  localparam reg_addr_t ZERO_REG = reg_addr_t'(31);

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Valid/ready request bundle from the completing units to the write arbiter.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 3
) ();
  import regfile_pkg::*;

  logic      [NUM_REQ-1:0] req_valid;
  logic      [NUM_REQ-1:0] req_ready;
  reg_addr_t [NUM_REQ-1:0] req_addr;
  reg_data_t [NUM_REQ-1:0] req_data;

  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from rr_ptr_reg upward with wrap, advances past the winner on a transfer.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               hold,
  input  logic               xfer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] rr_ptr_next;
  logic             found;

  always_comb begin
    int cand;
    cand      = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr_reg) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

  assign rr_ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant[gi] = found & ~hold & (grant_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
    end else if (xfer) begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single regfile write port among NUM_REQ units; registered write plus same-cycle forwarding.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_write_arbiter_if.slave  req_if,
  input  logic                    hold,
  output logic                    regWrite,
  output reg_addr_t               writeAddr,
  output reg_data_t               WriteData,
  input  reg_addr_t               readAddr1,
  input  reg_addr_t               readAddr2,
  output logic                    fwd_hit1,
  output logic                    fwd_hit2,
  output reg_data_t               fwd_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ready;
  logic [IDX_W-1:0]   grant_idx;
  logic               xfer;
  wr_req_t            sel;
  wr_req_t            out_reg;
  logic               wen_reg;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_if.req_valid),
    .hold      (hold),
    .xfer      (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // No accepts while reset is held, so requesters keep their payload for re-arbitration.
  assign ready          = grant & {NUM_REQ{rst_n}};
  assign req_if.req_ready = ready;
  assign xfer           = |(req_if.req_valid & ready);

  always_comb begin
    sel.addr = req_if.req_addr[grant_idx];
    sel.data = req_if.req_data[grant_idx];
  end

  // Zero-register writes are accepted to keep the requester moving but never enable the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_reg <= 1'b0;
      out_reg <= '0;
    end else if (xfer) begin
      wen_reg <= (sel.addr != ZERO_REG);
      out_reg <= sel;
    end else begin
      wen_reg <= 1'b0;
    end
  end

  assign regWrite  = wen_reg;
  assign writeAddr = out_reg.addr;
  assign WriteData = out_reg.data;

  assign fwd_hit1 = wen_reg & (out_reg.addr == readAddr1) & (readAddr1 != ZERO_REG);
  assign fwd_hit2 = wen_reg & (out_reg.addr == readAddr2) & (readAddr2 != ZERO_REG);
  assign fwd_data = out_reg.data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: expected writes are queued at acceptance and checked one cycle later.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  typedef struct {
    logic      wen;
    reg_addr_t addr;
    reg_data_t data;
  } exp_t;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      hold;
  logic      regWrite;
  reg_addr_t writeAddr;
  reg_data_t WriteData;
  reg_addr_t readAddr1;
  reg_addr_t readAddr2;
  logic      fwd_hit1;
  logic      fwd_hit2;
  reg_data_t fwd_data;

  int        errors = 0;
  int        checks = 0;
  exp_t      q[$];
  reg_addr_t last_addr;
  reg_data_t last_data;

  regfile_write_arbiter_if #(.NUM_REQ(3)) rif ();

  regfile_write_arbiter #(.NUM_REQ(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_if    (rif.slave),
    .hold      (hold),
    .regWrite  (regWrite),
    .writeAddr (writeAddr),
    .WriteData (WriteData),
    .readAddr1 (readAddr1),
    .readAddr2 (readAddr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data  (fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check ready and last cycle's write at negedge, queue this cycle's accept.
  task automatic cycle(input string tag, input logic [2:0] exp_ready);
    exp_t e;
    exp_t n;
    logic h1;
    logic h2;
    @(negedge clk);
    chk({tag, " ready"}, 64'(rif.req_ready), 64'(exp_ready));
    if (q.size() > 0) e = q.pop_front();
    else e = '{1'b0, last_addr, last_data};
    h1 = e.wen && (e.addr == readAddr1) && (readAddr1 != reg_addr_t'(31));
    h2 = e.wen && (e.addr == readAddr2) && (readAddr2 != reg_addr_t'(31));
    chk({tag, " regWrite"}, 64'(regWrite), 64'(e.wen));
    chk({tag, " writeAddr"}, 64'(writeAddr), 64'(e.addr));
    chk({tag, " WriteData"}, WriteData, e.data);
    chk({tag, " fwd_hit1"}, 64'(fwd_hit1), 64'(h1));
    chk({tag, " fwd_hit2"}, 64'(fwd_hit2), 64'(h2));
    chk({tag, " fwd_data"}, fwd_data, e.data);
    n = '{1'b0, last_addr, last_data};
    for (int i = 0; i < 3; i++) begin
      if (rif.req_valid[i] && exp_ready[i]) begin
        n.addr = rif.req_addr[i];
        n.data = rif.req_data[i];
        n.wen  = (rif.req_addr[i] != reg_addr_t'(31));
      end
    end
    last_addr = n.addr;
    last_data = n.data;
    q.push_back(n);
    $display("cycle %s: ready=%b regWrite=%b addr=%0d data=%0h", tag, rif.req_ready, regWrite, writeAddr, WriteData);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    hold = 1'b0;
    readAddr1 = '0;
    readAddr2 = '0;
    last_addr = '0;
    last_data = '0;
    rif.req_valid = 3'b111;
    rif.req_addr[0] = 5'd1; rif.req_data[0] = 64'hA;
    rif.req_addr[1] = 5'd2; rif.req_data[1] = 64'hB;
    rif.req_addr[2] = 5'd3; rif.req_data[2] = 64'hC;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 64'(rif.req_ready), 64'd0);
    chk("reset regWrite", 64'(regWrite), 64'd0);
    chk("reset writeAddr", 64'(writeAddr), 64'd0);
    chk("reset WriteData", WriteData, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All three contending, held valid after accept.
    cycle("cont0", 3'b001);
    cycle("cont1", 3'b010);
    cycle("cont2", 3'b100);
    cycle("cont3", 3'b001);

    // Asynchronous reset while the req0 write sits in the output register.
    chk("prerst regWrite", 64'(regWrite), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst regWrite", 64'(regWrite), 64'd0);
    chk("rst writeAddr", 64'(writeAddr), 64'd0);
    chk("rst WriteData", WriteData, 64'd0);
    chk("rst ready", 64'(rif.req_ready), 64'd0);
    q.delete();
    last_addr = '0;
    last_data = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("rstrel0", 3'b001);
    cycle("rstrel1", 3'b010);

    // Pointer at 2 with only req0/req2 valid.
    rif.req_valid = 3'b101;
    cycle("wrap0", 3'b100);
    cycle("wrap1", 3'b001);
    cycle("wrap2", 3'b100);

    // Zero-register write is accepted but never enabled.
    rif.req_valid = 3'b010;
    rif.req_addr[1] = 5'd31;
    rif.req_data[1] = 64'hFF;
    readAddr1 = 5'd31;
    cycle("zero0", 3'b010);
    rif.req_valid = 3'b110;
    cycle("zero1", 3'b100);

    // Hold blocks grants but the pending req2 write still drives regWrite.
    rif.req_valid = 3'b001;
    rif.req_addr[0] = 5'd7;
    rif.req_data[0] = 64'h1234;
    readAddr1 = 5'd0;
    hold = 1'b1;
    cycle("hold0", 3'b000);
    cycle("hold1", 3'b000);
    cycle("hold2", 3'b000);
    hold = 1'b0;
    cycle("holdrel", 3'b001);

    // Forwarding of the addr-7 write.
    rif.req_valid = 3'b000;
    readAddr1 = 5'd7;
    readAddr2 = 5'd8;
    cycle("fwd0", 3'b000);
    cycle("fwd1", 3'b000);

    // Sole requester gets back-to-back grants.
    rif.req_addr[0] = 5'd9;
    rif.req_data[0] = 64'h99;
    rif.req_valid = 3'b001;
    cycle("b2b0", 3'b001);
    cycle("b2b1", 3'b001);
    rif.req_valid = 3'b000;
    cycle("drain", 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
